csr_access_unit: RTL and testbench



---
 rtl/csr_access_unit.sv | 203 ++++++++++++++++++++
 tb/tb_csr_access_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR access interface.
// Sequences one decoded SYSTEM-opcode CSR instruction into a read cycle and
// an optional single write/set/clear cycle, then returns the old CSR value.
// Optional feature macro: CSR_READONLY_CHECK_EN rejects writes to CSRs whose
// address bits [11:10] are 2'b11 (read-only space) before any access is issued.
module csr_access_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_value,
    output logic            ready,
    output logic [11:0]     csr_number,
    output logic [1:0]      csr_access_type,
    output logic [XLEN-1:0] csr_in,
    input  logic [XLEN-1:0] csr_out,
    output logic            done,
    output logic            illegal,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data
);

    localparam int unsigned CSR_W  = 12;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned TYPE_W = 2;

    localparam logic [TYPE_W-1:0] CSR_READ_ONLY = 2'b00;
    localparam logic [TYPE_W-1:0] CSR_WRITE     = 2'b01;
    localparam logic [TYPE_W-1:0] CSR_SET       = 2'b10;
    localparam logic [TYPE_W-1:0] CSR_CLEAR     = 2'b11;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [CSR_W-1:0]    csr_number_q, csr_number_d;
    logic [TYPE_W-1:0]   csr_access_type_q, csr_access_type_d;
    logic [XLEN-1:0]     csr_in_q, csr_in_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;
    logic                rd_we_q, rd_we_d;
    logic [REG_W-1:0]    rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic [XLEN-1:0]     old_q, old_d;
    logic [XLEN-1:0]     operand_q, operand_d;
    logic [TYPE_W-1:0]   acc_type_q, acc_type_d;
    logic                wr_en_q, wr_en_d;
    logic [REG_W-1:0]    rd_q, rd_d;

    logic [CSR_W-1:0]    dec_csr;
    logic [REG_W-1:0]    dec_src;
    logic [2:0]          dec_funct3;
    logic [REG_W-1:0]    dec_rd;
    logic [TYPE_W-1:0]   dec_type;
    logic                dec_write;
    logic                dec_ro_viol;
    logic                dec_illegal;
    logic [XLEN-1:0]     dec_operand;

    // Decode the instruction word presented on the request port.
    always_comb begin
        dec_csr     = instr[31:20];
        dec_src     = instr[19:15];
        dec_funct3  = instr[14:12];
        dec_rd      = instr[11:7];
        dec_type    = dec_funct3[1:0];
        dec_operand = dec_funct3[2] ? XLEN'(dec_src) : rs1_value;
        // Plain writes always write; set/clear with a zero source are pure reads.
        dec_write   = (dec_type == CSR_WRITE) || (dec_src != '0);
`ifdef CSR_READONLY_CHECK_EN
        dec_ro_viol = (dec_csr[11:10] == 2'b11) && dec_write;
`else
        dec_ro_viol = 1'b0;
`endif
        dec_illegal = (instr[6:0] != OPC_SYSTEM) || (dec_type == CSR_READ_ONLY) || dec_ro_viol;
    end

    // Next-state and next-output logic; outputs reflect the state being entered.
    always_comb begin
        state_d           = state_q;
        csr_number_d      = csr_number_q;
        csr_in_d          = csr_in_q;
        rd_addr_d         = rd_addr_q;
        rd_data_d         = rd_data_q;
        old_d             = old_q;
        operand_d         = operand_q;
        acc_type_d        = acc_type_q;
        wr_en_d           = wr_en_q;
        rd_d              = rd_q;
        csr_access_type_d = CSR_READ_ONLY;
        done_d            = 1'b0;
        illegal_d         = 1'b0;
        rd_we_d           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    rd_d       = dec_rd;
                    operand_d  = dec_operand;
                    acc_type_d = dec_type;
                    wr_en_d    = dec_write;
                    if (dec_illegal) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                        rd_addr_d = dec_rd;
                        rd_data_d = '0;
                    end else begin
                        state_d      = READ;
                        csr_number_d = dec_csr;
                    end
                end
            end
            READ: begin
                old_d = csr_out;
                if (wr_en_q) begin
                    state_d           = WRITE;
                    csr_access_type_d = acc_type_q;
                    csr_in_d          = operand_q;
                end else begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    rd_addr_d = rd_q;
                    rd_data_d = csr_out;
                    rd_we_d   = (rd_q != '0);
                end
            end
            WRITE: begin
                state_d   = DONE;
                done_d    = 1'b1;
                rd_addr_d = rd_q;
                rd_data_d = old_q;
                rd_we_d   = (rd_q != '0);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            ready_q           <= 1'b1;
            csr_number_q      <= '0;
            csr_access_type_q <= CSR_READ_ONLY;
            csr_in_q          <= '0;
            done_q            <= 1'b0;
            illegal_q         <= 1'b0;
            rd_we_q           <= 1'b0;
            rd_addr_q         <= '0;
            rd_data_q         <= '0;
            old_q             <= '0;
            operand_q         <= '0;
            acc_type_q        <= CSR_READ_ONLY;
            wr_en_q           <= 1'b0;
            rd_q              <= '0;
        end else begin
            state_q           <= state_d;
            ready_q           <= ready_d;
            csr_number_q      <= csr_number_d;
            csr_access_type_q <= csr_access_type_d;
            csr_in_q          <= csr_in_d;
            done_q            <= done_d;
            illegal_q         <= illegal_d;
            rd_we_q           <= rd_we_d;
            rd_addr_q         <= rd_addr_d;
            rd_data_q         <= rd_data_d;
            old_q             <= old_d;
            operand_q         <= operand_d;
            acc_type_q        <= acc_type_d;
            wr_en_q           <= wr_en_d;
            rd_q              <= rd_d;
        end
    end

    assign ready           = ready_q;
    assign csr_number      = csr_number_q;
    assign csr_access_type = csr_access_type_q;
    assign csr_in          = csr_in_q;
    assign done            = done_q;
    assign illegal         = illegal_q;
    assign rd_we           = rd_we_q;
    assign rd_addr         = rd_addr_q;
    assign rd_data         = rd_data_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small CSR register file model.
// Exercises CSR_READONLY_CHECK_EN expectations when that macro is defined.
module tb_csr_access_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_value;
    logic            ready;
    logic [11:0]     csr_number;
    logic [1:0]      csr_access_type;
    logic [XLEN-1:0] csr_in;
    logic [XLEN-1:0] csr_out;
    logic            done;
    logic            illegal;
    logic            rd_we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    // Register file model state and a bench-side preload port.
    logic [XLEN-1:0] mtvec_m;
    logic [XLEN-1:0] mepc_m;
    logic            poke_en = 1'b0;
    logic [11:0]     poke_addr = '0;
    logic [XLEN-1:0] poke_data = '0;

    // Per-instruction observations.
    int              n_wr;
    logic [1:0]      wr_type;
    logic [XLEN-1:0] wr_in;
    logic [11:0]     wr_num;
    int              wr_cyc;

    int              lat;
    logic            o_ill;
    logic            o_we;
    logic [4:0]      o_ra;
    logic [XLEN-1:0] o_rd;

    csr_access_unit #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid           (valid),
        .instr           (instr),
        .rs1_value       (rs1_value),
        .ready           (ready),
        .csr_number      (csr_number),
        .csr_access_type (csr_access_type),
        .csr_in          (csr_in),
        .csr_out         (csr_out),
        .done            (done),
        .illegal         (illegal),
        .rd_we           (rd_we),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] apply_op(input logic [XLEN-1:0] cur,
                                                 input logic [1:0] typ,
                                                 input logic [XLEN-1:0] val);
        case (typ)
            2'b01:   return val;
            2'b10:   return cur | val;
            2'b11:   return cur & ~val;
            default: return cur;
        endcase
    endfunction

    // Combinational read port of the register file.
    always_comb begin
        case (csr_number)
            12'h305: csr_out = mtvec_m;
            12'h341: csr_out = mepc_m;
            default: csr_out = '0;
        endcase
    end

    // Register file commit: any non-read access type on a non-reset edge; read-only space ignores writes.
    always @(posedge clk) begin
        if (poke_en) begin
            if (poke_addr == 12'h305) mtvec_m <= poke_data;
            else                      mepc_m  <= poke_data;
        end else if (!reset && csr_access_type != 2'b00 && csr_number[11:10] != 2'b11) begin
            if (csr_number == 12'h305) mtvec_m <= apply_op(mtvec_m, csr_access_type, csr_in);
            if (csr_number == 12'h341) mepc_m  <= apply_op(mepc_m, csr_access_type, csr_in);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [11:0] addr, input logic [XLEN-1:0] data);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_data = data;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // Present one instruction, wait for accept, then track cycles until done.
    task automatic run(input string tag, input logic [31:0] ins, input logic [XLEN-1:0] rs1);
        int waits;
        bit got_done;
        @(negedge clk);
        valid     = 1'b1;
        instr     = ins;
        rs1_value = rs1;
        waits     = 0;
        while (!ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        check_eq({tag, "_accept_ready"}, 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        valid    = 1'b0;
        n_wr     = 0;
        wr_type  = 2'b00;
        wr_in    = '0;
        wr_num   = '0;
        wr_cyc   = 0;
        lat      = 0;
        got_done = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (csr_access_type != 2'b00) begin
                n_wr++;
                wr_type = csr_access_type;
                wr_in   = csr_in;
                wr_num  = csr_number;
                wr_cyc  = c;
            end
            if (done) begin
                lat   = c;
                o_ill = illegal;
                o_we  = rd_we;
                o_ra  = rd_addr;
                o_rd  = rd_data;
                got_done = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(got_done), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        valid     = 1'b0;
        instr     = '0;
        rs1_value = '0;
        poke(12'h305, 32'h0);
        poke(12'h341, 32'h0);
        @(posedge clk);
        #1;
        check_eq("rst_ready",   32'(ready),           32'd1);
        check_eq("rst_type",    32'(csr_access_type), 32'd0);
        check_eq("rst_number",  32'(csr_number),      32'd0);
        check_eq("rst_done",    32'(done),            32'd0);
        check_eq("rst_rd_data", rd_data,              32'd0);
        @(negedge clk);
        reset = 1'b0;

        // csrrw x5, mtvec, x1
        run("csrrw", 32'h305092F3, 32'h0000_1000);
        check_eq("csrrw_lat",    32'(lat),     32'd3);
        check_eq("csrrw_nwr",    32'(n_wr),    32'd1);
        check_eq("csrrw_wrcyc",  32'(wr_cyc),  32'd2);
        check_eq("csrrw_type",   32'(wr_type), 32'd1);
        check_eq("csrrw_in",     wr_in,        32'h1000);
        check_eq("csrrw_num",    32'(wr_num),  32'h305);
        check_eq("csrrw_ill",    32'(o_ill),   32'd0);
        check_eq("csrrw_we",     32'(o_we),    32'd1);
        check_eq("csrrw_ra",     32'(o_ra),    32'd5);
        check_eq("csrrw_rd",     o_rd,         32'h0);

        // csrrs x7, mtvec, x0 : pure read back, issued back-to-back
        run("rdback", 32'h305023F3, 32'hFFFF_FFFF);
        check_eq("rdback_lat", 32'(lat),  32'd2);
        check_eq("rdback_nwr", 32'(n_wr), 32'd0);
        check_eq("rdback_rd",  o_rd,      32'h1000);
        check_eq("rdback_ra",  32'(o_ra), 32'd7);

        // csrrs x6, mepc, x0 : read with suppressed set
        poke(12'h341, 32'h80);
        run("csrrs0", 32'h34102373, 32'h0);
        check_eq("csrrs0_lat", 32'(lat),  32'd2);
        check_eq("csrrs0_nwr", 32'(n_wr), 32'd0);
        check_eq("csrrs0_rd",  o_rd,      32'h80);
        check_eq("csrrs0_ra",  32'(o_ra), 32'd6);
        check_eq("csrrs0_we",  32'(o_we), 32'd1);

        // csrrci x0, mepc, 3
        poke(12'h341, 32'hFF);
        run("csrrci", 32'h3411F073, 32'h0);
        check_eq("csrrci_lat",  32'(lat),     32'd3);
        check_eq("csrrci_type", 32'(wr_type), 32'd3);
        check_eq("csrrci_in",   wr_in,        32'h3);
        check_eq("csrrci_we",   32'(o_we),    32'd0);
        check_eq("csrrci_rd",   o_rd,         32'hFF);
        check_eq("csrrci_mepc", mepc_m,       32'hFC);

        // csrrwi x0, mepc, 5 : writes even with rd == x0
        run("csrrwi", 32'h3412D073, 32'h0);
        check_eq("csrrwi_lat",  32'(lat),     32'd3);
        check_eq("csrrwi_type", 32'(wr_type), 32'd1);
        check_eq("csrrwi_in",   wr_in,        32'h5);
        check_eq("csrrwi_we",   32'(o_we),    32'd0);
        check_eq("csrrwi_mepc", mepc_m,       32'h5);

        // csrrsi x8, mepc, 16
        run("csrrsi", 32'h34186473, 32'h0);
        check_eq("csrrsi_type", 32'(wr_type), 32'd2);
        check_eq("csrrsi_in",   wr_in,        32'h10);
        check_eq("csrrsi_rd",   o_rd,         32'h5);
        check_eq("csrrsi_ra",   32'(o_ra),    32'd8);
        check_eq("csrrsi_mepc", mepc_m,       32'h15);

        // csrrc x9, mepc, x3 : operand comes from rs1_value, not the index
        run("csrrc", 32'h3411B4F3, 32'h4);
        check_eq("csrrc_type", 32'(wr_type), 32'd3);
        check_eq("csrrc_in",   wr_in,        32'h4);
        check_eq("csrrc_rd",   o_rd,         32'h15);
        check_eq("csrrc_mepc", mepc_m,       32'h11);

        // funct3 = 100 is illegal
        run("f3ill", 32'h30504073, 32'h0);
        check_eq("f3ill_lat", 32'(lat),   32'd1);
        check_eq("f3ill_ill", 32'(o_ill), 32'd1);
        check_eq("f3ill_we",  32'(o_we),  32'd0);
        check_eq("f3ill_nwr", 32'(n_wr),  32'd0);

        // Wrong opcode is illegal
        run("opill", 32'h30509233, 32'h1234);
        check_eq("opill_lat",   32'(lat),   32'd1);
        check_eq("opill_ill",   32'(o_ill), 32'd1);
        check_eq("opill_nwr",   32'(n_wr),  32'd0);
        check_eq("opill_mtvec", mtvec_m,    32'h1000);

        // Reset asserted during the WRITE cycle of csrrw x5, mtvec, x1
        @(negedge clk);
        while (!ready) @(negedge clk);
        valid     = 1'b1;
        instr     = 32'h305092F3;
        rs1_value = 32'h0000_2000;
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rstw_in_write", 32'(csr_access_type), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rstw_mtvec",   mtvec_m,              32'h1000);
        check_eq("rstw_ready",   32'(ready),           32'd1);
        check_eq("rstw_type",    32'(csr_access_type), 32'd0);
        check_eq("rstw_number",  32'(csr_number),      32'd0);
        check_eq("rstw_in",      csr_in,               32'd0);
        check_eq("rstw_done",    32'(done),            32'd0);
        check_eq("rstw_illegal", 32'(illegal),         32'd0);
        check_eq("rstw_rd_we",   32'(rd_we),           32'd0);
        check_eq("rstw_rd_addr", 32'(rd_addr),         32'd0);
        check_eq("rstw_rd_data", rd_data,              32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Read-only CSR space: csrrw x1, mhartid, x2 then csrrs x1, mhartid, x0
        run("rowr", 32'hF14110F3, 32'hDEAD_BEEF);
`ifdef CSR_READONLY_CHECK_EN
        check_eq("rowr_lat", 32'(lat),   32'd1);
        check_eq("rowr_ill", 32'(o_ill), 32'd1);
        check_eq("rowr_we",  32'(o_we),  32'd0);
        check_eq("rowr_nwr", 32'(n_wr),  32'd0);
`else
        check_eq("rowr_lat", 32'(lat),   32'd3);
        check_eq("rowr_ill", 32'(o_ill), 32'd0);
        check_eq("rowr_nwr", 32'(n_wr),  32'd1);
        check_eq("rowr_rd",  o_rd,       32'h0);
`endif
        run("rord", 32'hF14020F3, 32'h0);
        check_eq("rord_lat", 32'(lat),   32'd2);
        check_eq("rord_ill", 32'(o_ill), 32'd0);
        check_eq("rord_rd",  o_rd,       32'h0);
        check_eq("rord_we",  32'(o_we),  32'd1);
        check_eq("rord_ra",  32'(o_ra),  32'd1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
